// File: rtl/scale_sequencer.sv
// scale_sequencer
//   Auto-plays the C-major scale C4..C5 (eight notes) by driving the freq and
//   onOff inputs of tonegen. Each note sounds for NOTE_MS, then stays silent
//   for GAP_MS. Playback can run once or loop, and can ascend or descend.
//
// Parameters
//   FCLK     clock frequency in Hz; must be a multiple of 1000
//   NOTE_MS  sounding time per note in ms (>= 1)
//   GAP_MS   silent gap after each note in ms (0 = no gap)
//
// Ports
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   start     level request to begin playback; ignored while busy
//   stop      level abort; has priority over start
//   loop      sampled at the end of the last note: 1 = restart, 0 = finish
//   dir       captured when start is accepted: 0 = ascending, 1 = descending
//   freq      registered tone frequency in Hz
//   onOff     registered tone enable
//   busy      high while in PLAY or GAP
//   note_idx  index of the current note, for display
//   done      one-cycle pulse when a non-looped pass completes
module scale_sequencer #(
  parameter int unsigned FCLK    = 50000000,
  parameter int unsigned NOTE_MS = 250,
  parameter int unsigned GAP_MS  = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic        dir,
  output logic [31:0] freq,
  output logic        onOff,
  output logic        busy,
  output logic [2:0]  note_idx,
  output logic        done
);

  localparam logic [31:0] NOTE_CYC = 32'((FCLK / 1000) * NOTE_MS);
  localparam logic [31:0] GAP_CYC  = 32'((FCLK / 1000) * GAP_MS);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic        dir_q, dir_d;
  logic [2:0]  idx_d;
  logic        fin;        // non-looped pass ends on this edge
  logic [31:0] freq_d;
  logic        on_d;
  logic        done_d;

  function automatic logic [31:0] note_hz(input logic [2:0] i);
    case (i)
      3'd0:    note_hz = 32'd262;
      3'd1:    note_hz = 32'd294;
      3'd2:    note_hz = 32'd330;
      3'd3:    note_hz = 32'd349;
      3'd4:    note_hz = 32'd392;
      3'd5:    note_hz = 32'd440;
      3'd6:    note_hz = 32'd494;
      default: note_hz = 32'd523;
    endcase
  endfunction

  // State register; freq/onOff/done are registered from the comb next values
  // so they change on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_q    <= 1'b0;
      note_idx <= 3'd0;
      freq     <= '0;
      onOff    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      dir_q    <= dir_d;
      note_idx <= idx_d;
      freq     <= freq_d;
      onOff    <= on_d;
      done     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic decide;
    logic last;
    state_d = state;
    cnt_d   = cnt + 32'd1;
    dir_d   = dir_q;
    idx_d   = note_idx;
    fin     = 1'b0;
    decide  = 1'b0;
    last    = dir_q ? (note_idx == 3'd0) : (note_idx == 3'd7);

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          dir_d   = dir;
          idx_d   = dir ? 3'd7 : 3'd0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (cnt == NOTE_CYC - 32'd1) begin
          cnt_d = '0;
          // With no gap the note boundary is the decision point itself,
          // giving back-to-back PLAY without a dead cycle.
          if (GAP_CYC == 32'd0) decide  = 1'b1;
          else                  state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_CYC - 32'd1) decide = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (decide) begin
      cnt_d = '0;
      if (!last) begin
        idx_d   = dir_q ? note_idx - 3'd1 : note_idx + 3'd1;
        state_d = PLAY;
      end else if (loop) begin
        idx_d   = dir_q ? 3'd7 : 3'd0;
        state_d = PLAY;
      end else begin
        state_d = IDLE;
        fin     = 1'b1;
      end
    end

    // Abort wins over everything; the index is left for the display.
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      dir_d   = dir_q;
      idx_d   = note_idx;
      fin     = 1'b0;
    end
  end

  // Output logic (values registered above)
  always_comb begin
    freq_d = '0;
    on_d   = 1'b0;
    done_d = fin;
    case (state_d)
      PLAY: begin
        freq_d = note_hz(idx_d);
        on_d   = 1'b1;
      end
      GAP:     freq_d = freq;   // silent, but the pitch stays visible
      default: freq_d = '0;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_scale_sequencer.sv
module tb_scale_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, stop, loop, dir;
  logic [31:0] freq;
  logic        onOff, busy, done;
  logic [2:0]  note_idx;

  logic        start0, stop0, loop0, dir0;
  logic [31:0] freq0;
  logic        onOff0, busy0, done0;
  logic [2:0]  note_idx0;

  int errors = 0;
  int checks = 0;

  logic [31:0] tbl [0:7] = '{32'd262, 32'd294, 32'd330, 32'd349,
                             32'd392, 32'd440, 32'd494, 32'd523};

  scale_sequencer #(.FCLK(1000), .NOTE_MS(4), .GAP_MS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .dir(dir), .freq(freq), .onOff(onOff), .busy(busy), .note_idx(note_idx),
    .done(done)
  );

  scale_sequencer #(.FCLK(1000), .NOTE_MS(4), .GAP_MS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .stop(stop0), .loop(loop0),
    .dir(dir0), .freq(freq0), .onOff(onOff0), .busy(busy0), .note_idx(note_idx0),
    .done(done0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after E0, the edge that samples start.
  task automatic start_pass(input logic d, input logic l);
    start = 1'b1; dir = d; loop = l;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; stop = 0; loop = 0; dir = 0;
    start0 = 0; stop0 = 0; loop0 = 0; dir0 = 0;
    tick(); tick();
    checks++; if (freq !== 32'd0) begin errors++; $display("FAIL reset_freq got %0d want 0", freq); end
    checks++; if (onOff !== 1'b0) begin errors++; $display("FAIL reset_onOff got %b want 0", onOff); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (note_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", note_idx); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy0 !== 1'b0 || freq0 !== 32'd0) begin errors++; $display("FAIL reset_dut0 got busy=%b freq=%0d want 0/0", busy0, freq0); end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    start_pass(1'b0, 1'b0);
    for (int k = 0; k < 48; k++) begin
      if (k > 0) tick();
      checks++; if (freq !== tbl[k/6]) begin errors++; $display("FAIL asc_freq k=%0d got %0d want %0d", k, freq, tbl[k/6]); end
      checks++; if (onOff !== ((k % 6) < 4)) begin errors++; $display("FAIL asc_onOff k=%0d got %b want %b", k, onOff, ((k % 6) < 4)); end
      checks++; if (note_idx !== 3'(k/6)) begin errors++; $display("FAIL asc_idx k=%0d got %0d want %0d", k, note_idx, k/6); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL asc_busy k=%0d got busy=%b done=%b want 1/0", k, busy, done); end
    end
    tick(); // E48
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL asc_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL asc_end_busy got %b want 0", busy); end
    checks++; if (freq !== 32'd0 || onOff !== 1'b0) begin errors++; $display("FAIL asc_end_out got freq=%0d onOff=%b want 0/0", freq, onOff); end
    checks++; if (note_idx !== 3'd7) begin errors++; $display("FAIL asc_end_idx got %0d want 7", note_idx); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL asc_done_width got %b want 0", done); end
  endtask

  task automatic test_desc_loop();
    int idx;
    start_pass(1'b1, 1'b1);
    for (int k = 0; k < 54; k++) begin
      if (k > 0) tick();
      idx = 7 - ((k / 6) % 8);
      checks++; if (note_idx !== 3'(idx)) begin errors++; $display("FAIL desc_idx k=%0d got %0d want %0d", k, note_idx, idx); end
      checks++; if (freq !== tbl[idx]) begin errors++; $display("FAIL desc_freq k=%0d got %0d want %0d", k, freq, tbl[idx]); end
      checks++; if (onOff !== ((k % 6) < 4)) begin errors++; $display("FAIL desc_onOff k=%0d got %b want %b", k, onOff, ((k % 6) < 4)); end
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL desc_busy k=%0d got busy=%b done=%b want 1/0", k, busy, done); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || onOff !== 1'b0 || freq !== 32'd0) begin errors++; $display("FAIL desc_stop got busy=%b onOff=%b freq=%0d want 0/0/0", busy, onOff, freq); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL desc_stop_done got %b want 0", done); end
    checks++; if (note_idx !== 3'd7) begin errors++; $display("FAIL desc_stop_idx got %0d want 7", note_idx); end
    tick();
  endtask

  task automatic test_stop_mid();
    start_pass(1'b0, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    checks++; if (freq !== 32'd330 || onOff !== 1'b1) begin errors++; $display("FAIL stop_pre got freq=%0d onOff=%b want 330/1", freq, onOff); end
    stop = 1'b1;
    tick(); // E13
    stop = 1'b0;
    checks++; if (freq !== 32'd0) begin errors++; $display("FAIL stop_freq got %0d want 0", freq); end
    checks++; if (onOff !== 1'b0) begin errors++; $display("FAIL stop_onOff got %b want 0", onOff); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got %b want 0", done); end
    checks++; if (note_idx !== 3'd2) begin errors++; $display("FAIL stop_idx got %0d want 2", note_idx); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_after got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_contention();
    start = 1'b1; stop = 1'b1; dir = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || onOff !== 1'b0 || freq !== 32'd0) begin errors++; $display("FAIL cont_idle got busy=%b onOff=%b freq=%0d want 0/0/0", busy, onOff, freq); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle2 got %b want 0", busy); end
    start = 1'b0; stop = 1'b0;
    tick();
    start_pass(1'b0, 1'b0);
    for (int k = 0; k < 48; k++) begin
      if (k > 0) tick();
      checks++; if (freq !== tbl[k/6]) begin errors++; $display("FAIL ign_freq k=%0d got %0d want %0d", k, freq, tbl[k/6]); end
      checks++; if (onOff !== ((k % 6) < 4)) begin errors++; $display("FAIL ign_onOff k=%0d got %b want %b", k, onOff, ((k % 6) < 4)); end
      if (k == 2)  begin start = 1'b1; dir = 1'b1; end
      if (k == 5)  begin start = 1'b0; dir = 1'b0; end
      if (k == 45) start = 1'b1;
    end
    tick(); // E48: pass completes with start still held
    checks++; if (done !== 1'b1 || busy !== 1'b0 || freq !== 32'd0) begin errors++; $display("FAIL retrig_end got done=%b busy=%b freq=%0d want 1/0/0", done, busy, freq); end
    tick(); // E49: first IDLE cycle accepts the held start
    checks++; if (busy !== 1'b1 || onOff !== 1'b1 || freq !== 32'd262) begin errors++; $display("FAIL retrig_start got busy=%b onOff=%b freq=%0d want 1/1/262", busy, onOff, freq); end
    checks++; if (done !== 1'b0 || note_idx !== 3'd0) begin errors++; $display("FAIL retrig_state got done=%b idx=%0d want 0/0", done, note_idx); end
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL retrig_stop got %b want 0", busy); end
  endtask

  task automatic test_gap0();
    start0 = 1'b1; dir0 = 1'b0; loop0 = 1'b0;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      checks++; if (onOff0 !== 1'b1) begin errors++; $display("FAIL gap0_onOff k=%0d got %b want 1", k, onOff0); end
      checks++; if (freq0 !== tbl[k/4]) begin errors++; $display("FAIL gap0_freq k=%0d got %0d want %0d", k, freq0, tbl[k/4]); end
      checks++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL gap0_busy k=%0d got busy=%b done=%b want 1/0", k, busy0, done0); end
    end
    tick(); // E32
    checks++; if (done0 !== 1'b1 || onOff0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL gap0_end got done=%b onOff=%b busy=%b want 1/0/0", done0, onOff0, busy0); end
    tick();
  endtask

  task automatic test_async_reset();
    start_pass(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    checks++; if (onOff !== 1'b0 || freq !== 32'd294) begin errors++; $display("FAIL ar_pre got onOff=%b freq=%0d want 0/294", onOff, freq); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (freq !== 32'd0) begin errors++; $display("FAIL ar_freq got %0d want 0", freq); end
    checks++; if (onOff !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_onOff_busy got %b/%b want 0/0", onOff, busy); end
    checks++; if (note_idx !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL ar_idx_done got %0d/%b want 0/0", note_idx, done); end
    #2 reset_n = 1'b1;
    tick();
    start_pass(1'b0, 1'b0);
    checks++; if (freq !== 32'd262 || onOff !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_restart got freq=%0d onOff=%b busy=%b want 262/1/1", freq, onOff, busy); end
    checks++; if (note_idx !== 3'd0) begin errors++; $display("FAIL ar_restart_idx got %0d want 0", note_idx); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_desc_loop();
    test_stop_mid();
    test_contention();
    test_gap0();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scale_sequencer.md
# scale_sequencer

- Plays a fixed C-major-scale melody (C4 to C5, eight notes) by sequencing the tone generator's `freq` and `onOff` inputs.
- Timing per note: a programmable note time followed by a silent gap.
- Controls: start/stop, single-pass or looped playback, ascending or descending order.
- Placement: between the board's pushbutton/encoder control logic and `tonegen`. It replaces direct drive of `tone_freq`/`onOff` when auto-play is selected.

## Interface
- `FCLK`, 50000000, clock frequency in Hz; must be a multiple of 1000.
- `NOTE_MS`, 250, sounding time per note in ms; must be ≥1.
- `GAP_MS`, 50, silent gap after each note in ms; 0 is allowed and means no gap.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  level-sampled request to begin playback; ignored while `busy`=1.
- `stop`  in  1  level-sampled abort; has priority over `start`.
- `loop`  in  1  sampled at the end of the last note's gap: 1 = restart the sequence, 0 = finish.
- `dir`  in  1  captured when `start` is accepted: 0 = ascending (index 0→7), 1 = descending (index 7→0).
- `freq`  out  32  tone frequency in Hz for `tonegen`; a registered output.
- `onOff`  out  1  enables `tonegen`; a registered output.
- `busy`  out  1  high in states PLAY and GAP.
- `note_idx`  out  3  index of the current note, for display.
- `done`  out  1  one-cycle pulse when a non-looped pass completes.

## Operation
- Note table, index 0–7, in Hz: 262, 294, 330, 349, 392, 440, 494, 523.
- Derived cycle counts:
  - NOTE_CYC = (FCLK/1000)·NOTE_MS.
  - GAP_CYC = (FCLK/1000)·GAP_MS.
- Cycle counter: 32-bit, unsigned, loaded with 0 on every state entry.
- States: IDLE, PLAY, GAP.
- Reset (asynchronous, `reset_n`=0) forces:
  - state IDLE, counter 0, captured direction 0;
  - `freq`=0, `onOff`=0, `busy`=0, `note_idx`=0, `done`=0.
- IDLE:
  - `freq`=0, `onOff`=0.
  - When `start`=1 and `stop`=0:
    - capture `dir`;
    - load `note_idx` with 0 if ascending, 7 if descending;
    - go to PLAY.
- PLAY:
  - `freq`=table[`note_idx`], `onOff`=1.
  - After NOTE_CYC cycles in PLAY: go to GAP, or go directly to the next-note decision if GAP_CYC=0.
- GAP:
  - `onOff`=0; `freq` holds its current value.
  - After GAP_CYC cycles: make the next-note decision.
- Next-note decision:
  - Not the last note (index 7 ascending, or 0 descending): step the index ±1 and go to PLAY.
  - Last note with `loop`=1: reload the start index and go to PLAY. `done` does not pulse.
  - Last note with `loop`=0: go to IDLE with `freq`=0, `busy`=0, and `done`=1 for exactly one cycle.
- `stop`=1 in any state: go to IDLE on the next edge with `freq`=0 and `onOff`=0. `done` does not pulse, and `note_idx` holds its value.
- `start` held high after completion re-triggers on the first IDLE cycle. Edge detection is the caller's responsibility.
- `dir` and `loop` changing mid-pass: `dir` has no effect; `loop` is honoured only at the decision point.

## Timing
- Start latency: `start` sampled at edge E0 → `busy`=1, `onOff`=1, `freq`=table[start] are visible from E0 onward (one registered stage).
- `onOff` is high for exactly NOTE_CYC cycles per note, then low for exactly GAP_CYC cycles.
- Note period: NOTE_CYC+GAP_CYC cycles, with no dead cycle between GAP and the next PLAY.
- Full pass: 8·(NOTE_CYC+GAP_CYC) cycles from E0. `done` is high in the cycle after edge E0+8·(NOTE_CYC+GAP_CYC), and `busy` falls on the same edge.
- Stop latency: one edge.
- Simultaneous `start` and `stop` in IDLE: the block stays in IDLE.
- Reset mid-note: outputs clear immediately, without waiting for a clock edge.

## Test plan
All tests use `FCLK`=1000, `NOTE_MS`=4, `GAP_MS`=2, giving NOTE_CYC=4 and GAP_CYC=2.

- **Ascending single pass.** Pulse `start` at E0 with `dir`=0, `loop`=0.
  - `freq` steps through 262→294→…→523 every 6 cycles.
  - `onOff` is high for 4 cycles, then low for 2, each note.
  - `done` is a single pulse after E48; then `freq`=0 and `busy`=0.
- **Descending with loop.** Pulse `start` with `dir`=1 and `loop`=1.
  - Order is 523→…→262, then 523 again at E48.
  - `done` never asserts; `note_idx` wraps from 0 to 7.
- **Stop mid-note.** Assert `stop` at E13, during note 2 (330 Hz).
  - From E13: `freq`=0, `onOff`=0, `busy`=0, no `done`, `note_idx`=2.
- **Start/stop contention and retrigger.**
  - `start`=`stop`=1 in IDLE → remains IDLE.
  - `start` during PLAY → ignored, and the sequence timing is unchanged.
- **GAP_MS=0.** `onOff` stays continuously high for 32 cycles; `freq` changes every 4 cycles.
- **Asynchronous reset mid-GAP.** Drop `reset_n` between edges.
  - All outputs go to 0 before the next edge.
  - After release, a new `start` restarts at 262 Hz.
